// File: rtl/risc_ctrl_fsm_if.sv
// Control bus between the RISC control FSM and the datapath.
// The controller owns every strobe; the datapath supplies IR contents,
// the regfile port-P zero flag and the external start request.
interface risc_ctrl_fsm_if #(
   parameter int RFA_W = 4,
   parameter int ST_W  = 4
);
   logic [15:0]      ir_in;
   logic             rp_zero;
   logic             start;
   logic             pc_clr;
   logic             pc_ld;
   logic             pc_inc;
   logic             ir_ld;
   logic             d_addr_sel;
   logic             mem_rd;
   logic             mem_wr;
   logic [1:0]       rf_sel;
   logic             w_wr;
   logic [RFA_W-1:0] w_addr;
   logic             rp_rd;
   logic [RFA_W-1:0] rp_addr;
   logic             rq_rd;
   logic [RFA_W-1:0] rq_addr;
   logic [1:0]       alu_sel;
   logic             halted;
   logic [ST_W-1:0]  state_out;

   // Controller side: consumes status, drives strobes
   modport master (
      input  ir_in, rp_zero, start,
      output pc_clr, pc_ld, pc_inc, ir_ld, d_addr_sel, mem_rd, mem_wr,
             rf_sel, w_wr, w_addr, rp_rd, rp_addr, rq_rd, rq_addr,
             alu_sel, halted, state_out
   );

   // Datapath side: supplies status, obeys strobes
   modport slave (
      output ir_in, rp_zero, start,
      input  pc_clr, pc_ld, pc_inc, ir_ld, d_addr_sel, mem_rd, mem_wr,
             rf_sel, w_wr, w_addr, rp_rd, rp_addr, rq_rd, rq_addr,
             alu_sel, halted, state_out
   );
endinterface

// File: rtl/risc_ctrl_fsm.sv
// Moore control FSM for the 16-bit RISC core: fetch / decode / execute.
// Outputs depend only on the current state and the IR fields.
module risc_ctrl_fsm #(
   parameter int OPC_W = 4,
   parameter int RFA_W = 4,
   parameter int ST_W  = 4
) (
   input  logic          clk,
   input  logic          reset,
   risc_ctrl_fsm_if.master bus
);
   localparam logic [3:0] S_INIT   = 4'd0;
   localparam logic [3:0] S_FETCH  = 4'd1;
   localparam logic [3:0] S_DECODE = 4'd2;
   localparam logic [3:0] S_LD1    = 4'd3;
   localparam logic [3:0] S_LD2    = 4'd4;
   localparam logic [3:0] S_ST     = 4'd5;
   localparam logic [3:0] S_EXE    = 4'd6;
   localparam logic [3:0] S_LDI    = 4'd7;
   localparam logic [3:0] S_JMP    = 4'd8;
   localparam logic [3:0] S_JZ1    = 4'd9;
   localparam logic [3:0] S_JZ2    = 4'd10;
   localparam logic [3:0] S_HALT   = 4'd11;

   logic [ST_W-1:0]  state_reg;
   logic [ST_W-1:0]  state_next;
   logic [OPC_W-1:0] op;
   logic [OPC_W-1:0] alu_op;
   logic [RFA_W-1:0] ra;
   logic [RFA_W-1:0] rb;
   logic [RFA_W-1:0] rc;

   assign op     = bus.ir_in[15 -: OPC_W];
   assign ra     = bus.ir_in[11 -: RFA_W];
   assign rb     = bus.ir_in[7 -: RFA_W];
   assign rc     = bus.ir_in[3 -: RFA_W];
   // ADD/SUB/AND opcodes 3/4/5 map onto ALU selects 1/2/3
   assign alu_op = op - OPC_W'(2);

   // State register; reset wins over every transition
   always_ff @(posedge clk) begin
      if (!reset) state_reg <= S_INIT;
      else        state_reg <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = S_FETCH;
      case (state_reg)
         S_INIT:   state_next = S_FETCH;
         S_FETCH:  state_next = S_DECODE;
         S_DECODE: begin
            case (op)
               4'h1:                   state_next = S_LD1;
               4'h2:                   state_next = S_ST;
               4'h3, 4'h4, 4'h5:       state_next = S_EXE;
               4'h6:                   state_next = S_LDI;
               4'h7:                   state_next = S_JMP;
               4'h8:                   state_next = S_JZ1;
               4'hF:                   state_next = S_HALT;
               default:                state_next = S_FETCH;  // NOP and illegal opcodes
            endcase
         end
         S_LD1:    state_next = S_LD2;
         S_JZ1:    state_next = bus.rp_zero ? S_JZ2 : S_FETCH;
         S_HALT:   state_next = bus.start ? S_FETCH : S_HALT;
         default:  state_next = S_FETCH;
      endcase
   end

   // Moore output decode from state and IR fields
   always_comb begin
      bus.pc_clr     = 1'b0;
      bus.pc_ld      = 1'b0;
      bus.pc_inc     = 1'b0;
      bus.ir_ld      = 1'b0;
      bus.d_addr_sel = 1'b0;
      bus.mem_rd     = 1'b0;
      bus.mem_wr     = 1'b0;
      bus.rf_sel     = 2'd0;
      bus.w_wr       = 1'b0;
      bus.w_addr     = '0;
      bus.rp_rd      = 1'b0;
      bus.rp_addr    = '0;
      bus.rq_rd      = 1'b0;
      bus.rq_addr    = '0;
      bus.alu_sel    = 2'd0;
      bus.halted     = 1'b0;
      case (state_reg)
         S_INIT:   bus.pc_clr = 1'b1;
         S_FETCH: begin
            bus.mem_rd = 1'b1;
            bus.ir_ld  = 1'b1;
            bus.pc_inc = 1'b1;
         end
         S_LD1: begin
            bus.d_addr_sel = 1'b1;
            bus.mem_rd     = 1'b1;
         end
         S_LD2: begin
            bus.d_addr_sel = 1'b1;
            bus.mem_rd     = 1'b1;
            bus.rf_sel     = 2'd1;
            bus.w_wr       = 1'b1;
            bus.w_addr     = ra;
         end
         S_ST: begin
            bus.d_addr_sel = 1'b1;
            bus.rp_rd      = 1'b1;
            bus.rp_addr    = ra;
            bus.mem_wr     = 1'b1;
         end
         S_EXE: begin
            bus.rp_rd   = 1'b1;
            bus.rq_rd   = 1'b1;
            bus.rp_addr = rb;
            bus.rq_addr = rc;
            bus.alu_sel = alu_op[1:0];
            bus.w_wr    = 1'b1;
            bus.w_addr  = ra;
         end
         S_LDI: begin
            bus.rf_sel = 2'd2;
            bus.w_wr   = 1'b1;
            bus.w_addr = ra;
         end
         S_JMP, S_JZ2: bus.pc_ld = 1'b1;
         S_JZ1: begin
            bus.rp_rd   = 1'b1;
            bus.rp_addr = ra;
         end
         S_HALT:   bus.halted = 1'b1;
         default: ;
      endcase
   end

   assign bus.state_out = state_reg;
endmodule
